// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth recoder: partial-product mux select
// codes (in mux input order) and the sequencer state encoding.
package booth_pkg;

    localparam logic [2:0] OP_ZERO     = 3'd0;
    localparam logic [2:0] OP_MAIS_M   = 3'd1;
    localparam logic [2:0] OP_MAIS_2M  = 3'd2;
    localparam logic [2:0] OP_MENOS_M  = 3'd3;
    localparam logic [2:0] OP_MENOS_2M = 3'd4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        GERANDO = 2'd1,
        FIM     = 2'd2
    } state_e;

endpackage

// File: rtl/booth_digit_decode.sv
// Combinational radix-4 Booth digit decode: triplet (b2i+1, b2i, b2i-1)
// to a partial-product mux select code.
module booth_digit_decode
    import booth_pkg::*;
(
    input  logic [2:0] triplet_i,
    output logic [2:0] op_o
);

    always_comb begin
        op_o = OP_ZERO;
        case (triplet_i)
            3'b000:  op_o = OP_ZERO;
            3'b001:  op_o = OP_MAIS_M;
            3'b010:  op_o = OP_MAIS_M;
            3'b011:  op_o = OP_MAIS_2M;
            3'b100:  op_o = OP_MENOS_2M;
            3'b101:  op_o = OP_MENOS_M;
            3'b110:  op_o = OP_MENOS_M;
            3'b111:  op_o = OP_ZERO;
            default: op_o = OP_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_recoder_seq.sv
// Sequential radix-4 Booth recoder: latches a signed multiplier on iniciar and
// streams one select code per digit (LSD first) over a valid/ready handshake.
//
// state   | meaning
// OCIOSO  | idle, waiting for iniciar
// GERANDO | presenting digit indice, advances on pronto
// FIM     | one-cycle completion pulse, then back to OCIOSO
module booth_recoder_seq
    import booth_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic [N-1:0]  multiplicador,
    input  logic          pronto,
    output logic [2:0]    op,
    output logic          op_valido,
    output logic [IW-1:0] indice,
    output logic          ultimo,
    output logic          ocupado,
    output logic          fim
);

    localparam logic [IW-1:0] IDX_ULTIMO = IW'(N / 2 - 1);

    state_e        state_q;
    logic [N:0]    r_q;
    logic [IW-1:0] idx_q;
    logic [2:0]    op_dec;

    booth_digit_decode u_decode (
        .triplet_i (r_q[2:0]),
        .op_o      (op_dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OCIOSO;
            r_q     <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                OCIOSO: begin
                    if (iniciar) begin
                        r_q     <= {multiplicador, 1'b0};
                        idx_q   <= '0;
                        state_q <= GERANDO;
                    end
                end
                GERANDO: begin
                    if (pronto) begin
                        if (idx_q == IDX_ULTIMO) begin
                            state_q <= FIM;
                        end else begin
                            // Arithmetic shift keeps the sign for the upper triplets
                            r_q   <= {{2{r_q[N]}}, r_q[N:2]};
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                FIM:     state_q <= OCIOSO;
                default: state_q <= OCIOSO;
            endcase
        end
    end

    assign op_valido = (state_q == GERANDO);
    assign op        = op_valido ? op_dec : OP_ZERO;
    assign indice    = idx_q;
    assign ultimo    = op_valido && (idx_q == IDX_ULTIMO);
    assign ocupado   = (state_q != OCIOSO);
    assign fim       = (state_q == FIM);

endmodule

// File: tb/tb_booth_recoder_seq.sv
// Directed self-checking bench for booth_recoder_seq with hand-computed digit
// sequences (octal constants list digit 7 down to digit 0).
module tb_booth_recoder_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [15:0] multiplicador;
    logic        pronto;
    logic [2:0]  op;
    logic        op_valido;
    logic [2:0]  indice;
    logic        ultimo;
    logic        ocupado;
    logic        fim;

    int n_checks = 0;
    int n_pass   = 0;

    booth_recoder_seq #(.N(16), .IW(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .multiplicador (multiplicador),
        .pronto        (pronto),
        .op            (op),
        .op_valido     (op_valido),
        .indice        (indice),
        .ultimo        (ultimo),
        .ocupado       (ocupado),
        .fim           (fim)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int weight(input logic [2:0] o);
        case (o)
            3'd0:    return 0;
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return -1;
            3'd4:    return -2;
            default: return 1000000;
        endcase
    endfunction

    // Runs one full sequence; optional stall and ignored-start pokes.
    task automatic run_seq(input string name, input logic [15:0] m, input logic [23:0] ops,
                           input int stall_at, input int stall_n, input bit poke);
        longint sum;
        longint pw;
        logic [2:0] e;
        sum = 0;
        pw  = 1;
        multiplicador = m;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        multiplicador = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            e = ops[3*i +: 3];
            if (i == stall_at) begin
                pronto = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    n_checks++;
                    if (op !== e || indice !== 3'(i) || op_valido !== 1'b1 || ultimo !== (i == 7)) $display("FAIL %s stall d%0d: op=%0d idx=%0d v=%b ult=%b, want op=%0d idx=%0d v=1 ult=%b", name, i, op, indice, op_valido, ultimo, e, i, (i == 7));
                    else n_pass++;
                end
                pronto = 1'b1;
            end
            n_checks++;
            if (op_valido !== 1'b1 || op !== e || indice !== 3'(i) || ultimo !== (i == 7) || ocupado !== 1'b1 || fim !== 1'b0)
                $display("FAIL %s digit%0d: v=%b op=%0d idx=%0d ult=%b busy=%b fim=%b, want v=1 op=%0d idx=%0d ult=%b busy=1 fim=0", name, i, op_valido, op, indice, ultimo, ocupado, fim, e, i, (i == 7));
            else n_pass++;
            sum += longint'(weight(op)) * pw;
            pw  *= 4;
            if (poke && i == 3) begin
                iniciar = 1'b1;
                multiplicador = 16'hFFFF;
            end
            tick();
            iniciar = 1'b0;
        end
        n_checks++;
        if (fim !== 1'b1 || op_valido !== 1'b0 || ocupado !== 1'b1 || op !== 3'd0)
            $display("FAIL %s fim_cycle: fim=%b v=%b busy=%b op=%0d, want fim=1 v=0 busy=1 op=0", name, fim, op_valido, ocupado, op);
        else n_pass++;
        if (poke) begin
            iniciar = 1'b1;
            multiplicador = 16'hFFFF;
        end
        tick();
        iniciar = 1'b0;
        n_checks++;
        if (fim !== 1'b0 || op_valido !== 1'b0 || ocupado !== 1'b0)
            $display("FAIL %s idle_after: fim=%b v=%b busy=%b, want 0 0 0", name, fim, op_valido, ocupado);
        else n_pass++;
        n_checks++;
        if (sum !== longint'($signed(m)))
            $display("FAIL %s weighted_sum: got %0d, want %0d", name, sum, $signed(m));
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b1;
        multiplicador = 16'h0003;
        tick();
        tick();
        n_checks++;
        if (op !== 3'd0 || op_valido !== 1'b0 || ultimo !== 1'b0 || ocupado !== 1'b0 || fim !== 1'b0 || indice !== 3'd0)
            $display("FAIL reset_state: op=%0d v=%b ult=%b busy=%b fim=%b idx=%0d, want all 0", op, op_valido, ultimo, ocupado, fim, indice);
        else n_pass++;
        iniciar = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++;
        if (op_valido !== 1'b0 || ocupado !== 1'b0)
            $display("FAIL reset_idle: v=%b busy=%b, want 0 0", op_valido, ocupado);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_seq("m0003", 16'h0003, 24'o00000013, -1, 0, 1'b0);
        tick();
        n_checks++;
        if (op_valido !== 1'b0 || fim !== 1'b0 || ocupado !== 1'b0)
            $display("FAIL m0003_stays_idle: v=%b fim=%b busy=%b, want 0 0 0", op_valido, fim, ocupado);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        run_seq("m8000", 16'h8000, 24'o40000000, -1, 0, 1'b0);
        run_seq("mFFFF", 16'hFFFF, 24'o00000003, -1, 0, 1'b0);
        run_seq("m5555", 16'h5555, 24'o11111111, -1, 0, 1'b0);
        run_seq("m0006", 16'h0006, 24'o00000024, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_seq("stall0006", 16'h0006, 24'o00000024, 1, 3, 1'b0);
        run_seq("stall8000", 16'h8000, 24'o40000000, 7, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq("ignore0003", 16'h0003, 24'o00000013, -1, 0, 1'b1);
        run_seq("b2b5555", 16'h5555, 24'o11111111, -1, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        multiplicador = 16'h0003;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (indice !== 3'd4 || op_valido !== 1'b1)
            $display("FAIL pre_reset_digit: idx=%0d v=%b, want 4 1", indice, op_valido);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (op_valido !== 1'b0 || ocupado !== 1'b0 || indice !== 3'd0 || fim !== 1'b0 || op !== 3'd0)
            $display("FAIL mid_reset: v=%b busy=%b idx=%0d fim=%b op=%0d, want 0 0 0 0 0", op_valido, ocupado, indice, fim, op);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (fim !== 1'b0 || op_valido !== 1'b0)
                $display("FAIL no_resume c%0d: fim=%b v=%b, want 0 0", i, fim, op_valido);
            else n_pass++;
        end
        run_seq("after_reset0003", 16'h0003, 24'o00000013, -1, 0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        multiplicador = '0;
        pronto = 1'b1;
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
